// File: rtl/spdif_pkg.sv
// Shared constants and helpers for the S/PDIF (IEC 60958 consumer) transmitter.
package spdif_pkg;

    localparam int FRAMES_PER_BLOCK   = 192;
    localparam int SLOTS_PER_SUBFRAME = 32;

    // Preamble half-cell patterns, MSB first, for a preceding line level of 0.
    localparam logic [7:0] PREAMBLE_B = 8'b11101000;
    localparam logic [7:0] PREAMBLE_M = 8'b11100010;
    localparam logic [7:0] PREAMBLE_W = 8'b11100100;

    // Time-slot positions inside a subframe.
    localparam int SLOT_SAMPLE_LSB = 12;
    localparam int SLOT_SAMPLE_MSB = 27;
    localparam int SLOT_CHAN_STAT  = 30;
    localparam int SLOT_PARITY     = 31;

    // Channel-status bit indices.
    localparam int CS_BIT_COPY   = 2;
    localparam int CS_BIT_CAT_LO = 8;
    localparam int CS_BIT_CAT_HI = 15;
    localparam int CS_BIT_FS_LO  = 24;
    localparam int CS_BIT_FS_HI  = 27;

    // Sample-rate codes for channel-status bits 27..24.
    localparam logic [3:0] FS_CODE_48K = 4'b0010;
    localparam logic [3:0] FS_CODE_96K = 4'b1010;

    typedef logic [7:0] frame_t;
    typedef logic [4:0] slot_t;

    // Channel-status bit for a given frame of the 192-frame block.
    function automatic logic cs_bit(input frame_t frame, input logic copy,
                                    input logic [7:0] category, input logic rate96);
        logic [3:0] fsCode;
        fsCode = rate96 ? FS_CODE_96K : FS_CODE_48K;
        if (int'(frame) == CS_BIT_COPY)
            return copy;
        else if (int'(frame) >= CS_BIT_CAT_LO && int'(frame) <= CS_BIT_CAT_HI)
            return category[frame[2:0]];
        else if (int'(frame) >= CS_BIT_FS_LO && int'(frame) <= CS_BIT_FS_HI)
            return fsCode[frame[1:0]];
        return 1'b0;
    endfunction

endpackage

// File: rtl/spdif_bmc.sv
// Line-level register with biphase-mark coding and preamble inversion.
module spdif_bmc
    import spdif_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_ce,
    input  logic i_halfCell,
    input  logic i_preStart,
    input  logic i_isPreamble,
    input  logic i_preambleBit,
    input  logic i_dataBit,
    output logic o_line
);

    logic r_line;
    logic r_invert;
    logic w_invert;

    // The preamble polarity follows the line level present just before slot 0.
    assign w_invert = i_preStart ? r_line : r_invert;

    // Drive the line one half-cell per ce: raw preamble pattern or biphase-mark data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line   <= 1'b0;
            r_invert <= 1'b0;
        end else if (i_ce) begin
            if (i_preStart)
                r_invert <= r_line;
            if (i_isPreamble)
                r_line <= i_preambleBit ^ w_invert;
            else if (!i_halfCell)
                r_line <= ~r_line;
            else
                r_line <= r_line ^ i_dataBit;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF transmitter: frame/slot sequencing, sample latching and channel status.
module spdif_tx
    import spdif_pkg::*;
#(
    parameter logic       CS_COPY     = 1'b1,
    parameter logic [7:0] CS_CATEGORY = 8'h00
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        sample_rate,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    output logic        sample_ack,
    output logic        spdif
);

    localparam slot_t  LAST_SLOT  = slot_t'(SLOTS_PER_SUBFRAME - 1);
    localparam frame_t LAST_FRAME = frame_t'(FRAMES_PER_BLOCK - 1);

    logic        r_halfCell;
    slot_t       r_slot;
    logic        r_subframe;
    frame_t      r_frame;
    logic [15:0] r_left;
    logic [15:0] r_right;
    logic        r_rate;
    logic        r_ack;

    logic        w_frameStart;
    logic        w_preStart;
    logic        w_isPreamble;
    logic [7:0]  w_preamble;
    logic [2:0]  w_preIdx;
    logic        w_preambleBit;
    logic [15:0] w_sample;
    logic        w_cBit;
    logic        w_parity;
    logic [3:0]  w_sampleIdx;
    logic        w_dataBit;

    assign w_preStart    = (r_slot == '0) && !r_halfCell;
    assign w_frameStart  = w_preStart && !r_subframe;
    assign w_isPreamble  = (r_slot[4:2] == 3'd0);
    assign w_preamble    = r_subframe ? PREAMBLE_W : ((r_frame == '0) ? PREAMBLE_B : PREAMBLE_M);
    assign w_preIdx      = {r_slot[1:0], r_halfCell};
    assign w_preambleBit = w_preamble[3'd7 - w_preIdx];
    assign w_sample      = r_subframe ? r_right : r_left;
    assign w_cBit        = cs_bit(r_frame, CS_COPY, CS_CATEGORY, r_rate);
    assign w_parity      = (^w_sample) ^ w_cBit;
    assign w_sampleIdx   = 4'(r_slot - slot_t'(SLOT_SAMPLE_LSB));

    // Select the data bit carried by the current slot (aux, V and U slots stay 0).
    always_comb begin
        w_dataBit = 1'b0;
        if (r_slot >= slot_t'(SLOT_SAMPLE_LSB) && r_slot <= slot_t'(SLOT_SAMPLE_MSB))
            w_dataBit = w_sample[w_sampleIdx];
        else if (r_slot == slot_t'(SLOT_CHAN_STAT))
            w_dataBit = w_cBit;
        else if (r_slot == slot_t'(SLOT_PARITY))
            w_dataBit = w_parity;
    end

    // Half-cell, slot, subframe and frame counters chained as one position counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halfCell <= 1'b0;
            r_slot     <= '0;
            r_subframe <= 1'b0;
            r_frame    <= '0;
        end else if (ce) begin
            r_halfCell <= ~r_halfCell;
            if (r_halfCell) begin
                r_slot <= r_slot + 5'd1;
                if (r_slot == LAST_SLOT) begin
                    r_subframe <= ~r_subframe;
                    if (r_subframe)
                        r_frame <= (r_frame == LAST_FRAME) ? '0 : r_frame + 8'd1;
                end
            end
        end
    end

    // Latch both channels at the start of every frame and the rate at the start of a block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left  <= '0;
            r_right <= '0;
            r_rate  <= 1'b0;
        end else if (ce && w_frameStart) begin
            r_left  <= left_in;
            r_right <= right_in;
            if (r_frame == '0)
                r_rate <= sample_rate;
        end
    end

    // One-clock acknowledge following the latching edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ack <= 1'b0;
        else
            r_ack <= ce && w_frameStart;
    end

    spdif_bmc u_bmc (
        .clk          (clk),
        .reset        (reset),
        .i_ce         (ce),
        .i_halfCell   (r_halfCell),
        .i_preStart   (w_preStart),
        .i_isPreamble (w_isPreamble),
        .i_preambleBit(w_preambleBit),
        .i_dataBit    (w_dataBit),
        .o_line       (spdif)
    );

    assign sample_ack = r_ack;

endmodule

// File: tb/tb_spdif_tx.sv
// Scoreboard bench for spdif_tx: stimulus queues expected subframes, a line decoder checks them.
module tb_spdif_tx;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        sample_rate;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        sample_ack;
    logic        spdif;

    typedef struct {
        logic [7:0]  pre;
        logic [15:0] sample;
        logic        cBit;
    } expected_t;

    expected_t   expQ[$];
    int          nVectors      = 0;
    int          nMiscompares  = 0;
    int          hcCount       = 0;
    int          framesStarted = 0;
    int          ackCount      = 0;
    logic        modelRate     = 1'b0;
    logic        useFixed      = 1'b0;
    logic [15:0] fixL          = '0;
    logic [15:0] fixR          = '0;
    logic        randomGaps    = 1'b0;
    int          fixedGap      = 0;
    logic [63:0] monBuf        = '0;
    int          monIdx        = 0;
    logic        lineBefore    = 1'b0;

    spdif_tx dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .sample_rate(sample_rate),
        .left_in    (left_in),
        .right_in   (right_in),
        .sample_ack (sample_ack),
        .spdif      (spdif)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every clock on which the acknowledge is high; one per latched frame is expected.
    always @(negedge clk) begin
        if (sample_ack === 1'b1)
            ackCount++;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Consumer channel status with default parameters: copy bit, rate code bits 24..27.
    function automatic logic csBit(input int frame, input logic rate96);
        case (frame)
            2:       return 1'b1;
            25:      return 1'b1;
            27:      return rate96;
            default: return 1'b0;
        endcase
    endfunction

    task automatic startFrame();
        int        frame;
        expected_t e;
        frame = (hcCount / 128) % 192;
        if (useFixed) begin
            left_in  = fixL;
            right_in = fixR;
        end else begin
            left_in  = 16'($urandom);
            right_in = 16'($urandom);
        end
        if (frame == 0)
            modelRate = sample_rate;
        e.pre    = (frame == 0) ? 8'b11101000 : 8'b11100010;
        e.sample = left_in;
        e.cBit   = csBit(frame, modelRate);
        expQ.push_back(e);
        e.pre    = 8'b11100100;
        e.sample = right_in;
        expQ.push_back(e);
        framesStarted++;
    endtask

    task automatic applyStimulus();
        int gap;
        gap = fixedGap;
        if (randomGaps && $urandom_range(31) == 0)
            gap = int'($urandom_range(3, 1));
        if (gap > 0) begin
            ce = 1'b0;
            repeat (gap) @(negedge clk);
        end
        if (hcCount % 128 == 0)
            startFrame();
        else if (!useFixed) begin
            left_in  = 16'($urandom);
            right_in = 16'($urandom);
        end
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        hcCount++;
    endtask

    task automatic decodeSubframe();
        logic [7:0]  pre;
        logic [31:0] bits;
        int          violations;
        expected_t   e;
        bits       = '0;
        violations = 0;
        for (int i = 0; i < 8; i++)
            pre[7-i] = monBuf[i] ^ lineBefore;
        for (int s = 4; s < 32; s++) begin
            if (monBuf[2*s] == monBuf[2*s-1])
                violations++;
            bits[s] = monBuf[2*s] ^ monBuf[2*s+1];
        end
        lineBefore = monBuf[63];
        if (expQ.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL unexpected_subframe: got a subframe, expected none queued");
            return;
        end
        e = expQ.pop_front();
        checkOutput("preamble", 32'(pre), 32'(e.pre));
        checkOutput("sample", 32'(bits[27:12]), 32'(e.sample));
        checkOutput("c_bit", 32'(bits[30]), 32'(e.cBit));
        checkOutput("aux_v_u", 32'({bits[29:28], bits[11:4]}), 32'd0);
        checkOutput("parity", 32'(^bits[31:4]), 32'd0);
        checkOutput("bmc_cell_edges", 32'(violations), 32'd0);
    endtask

    // Line decoder: capture one half-cell after each qualifying edge, check each full subframe.
    initial begin : monitorProc
        forever begin
            @(posedge clk);
            if (reset) begin
                monIdx     = 0;
                lineBefore = 1'b0;
            end else if (ce) begin
                #1;
                monBuf[monIdx] = spdif;
                monIdx++;
                if (monIdx == 64) begin
                    decodeSubframe();
                    monIdx = 0;
                end
            end
        end
    end

    task automatic freezeCheck();
        logic held;
        int   changes;
        held    = spdif;
        changes = 0;
        ce      = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (spdif !== held)
                changes++;
        end
        checkOutput("freeze_spdif", 32'(changes), 32'd0);
    endtask

    task automatic midFrameReset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_async_spdif", 32'(spdif), 32'd0);
        checkOutput("reset_async_ack", 32'(sample_ack), 32'd0);
        @(negedge clk);
        expQ.delete();
        hcCount = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ce          = 1'b0;
        sample_rate = 1'b0;
        left_in     = '0;
        right_in    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_spdif", 32'(spdif), 32'd0);
        checkOutput("reset_ack", 32'(sample_ack), 32'd0);
        reset = 1'b0;

        // Slow enable, fixed extreme samples.
        useFixed = 1'b1;
        fixL     = 16'h8001;
        fixR     = 16'h7FFE;
        fixedGap = 3;
        repeat (3 * 128) applyStimulus();
        checkOutput("ack_count_slow", 32'(ackCount), 32'(framesStarted));
        checkOutput("queue_drained_slow", 32'(expQ.size()), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expQ.delete();
        hcCount = 0;
        reset   = 1'b0;

        // Full-rate enable with occasional gaps, two whole blocks plus part of a third.
        fixedGap    = 0;
        randomGaps  = 1'b1;
        sample_rate = 1'b1;
        for (int f = 0; f < 384 + 38; f++) begin
            useFixed = ((f % 192) == 5) || ((f % 192) == 6);
            fixL     = ((f % 192) == 5) ? 16'h0000 : 16'hFFFF;
            fixR     = fixL;
            if (f == 100)
                sample_rate = 1'b0;
            if (f == 250)
                sample_rate = 1'b1;
            for (int h = 0; h < 128; h++) begin
                if (f == 50 && h == 41)
                    freezeCheck();
                if (f == 384 + 37 && h == 30) begin
                    midFrameReset();
                    break;
                end
                applyStimulus();
            end
        end

        // New inputs after the aborted frame must appear in a fresh block starting with B.
        useFixed   = 1'b1;
        randomGaps = 1'b0;
        fixL       = 16'h1234;
        fixR       = 16'hEDCB;
        repeat (256) applyStimulus();
        repeat (4) @(negedge clk);
        checkOutput("queue_drained_end", 32'(expQ.size()), 32'd0);
        checkOutput("ack_count", 32'(ackCount), 32'(framesStarted));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/spdif_tx.md
SPDIF_TX -- requirements
Module: spdif_tx

Interface
REQ-001 The module SHALL have parameter CS_COPY, default 1, meaning the channel-status bit 2 value (copy permitted).
REQ-002 The module SHALL have parameter CS_CATEGORY, default 8'h00, meaning channel-status bits 8-15, LSB first.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port ce, input, 1 bit: half-cell enable, pulsed at 128 x fs (6.144 MHz at 48 kHz, 12.288 MHz at 96 kHz).
REQ-006 The module SHALL have port sample_rate, input, 1 bit: 0 = 48 kHz, 1 = 96 kHz; affects channel status only.
REQ-007 The module SHALL have port left_in, input, 16 bits: signed left sample.
REQ-008 The module SHALL have port right_in, input, 16 bits: signed right sample.
REQ-009 The module SHALL have port sample_ack, output, 1 bit: one-clk pulse when left_in/right_in are latched.
REQ-010 The module SHALL have port spdif, output, 1 bit: IEC 60958 biphase-mark line output.

Function
REQ-011 All state SHALL advance only on clk edges with ce=1; with ce=0 all state and spdif SHALL hold.
REQ-012 Counters SHALL be: half-cell 0-1, slot 0-31, subframe 0-1 (0=left, 1=right), frame 0-191.
REQ-013 Each ce SHALL advance half-cell; half-cell wrap SHALL advance slot; slot wrap SHALL advance subframe; subframe wrap SHALL advance frame; frame 191 SHALL wrap to 0.
REQ-014 On the ce that starts frame slot 0, subframe 0, half-cell 0, left_in and right_in SHALL be latched together, and sample_ack SHALL pulse on the next clk.
REQ-015 The latched pair SHALL be transmitted in that same frame, giving a latency of 0 frames from latch to first audio bit.
REQ-016 Slots 0-3 SHALL carry the preamble as 8 half-cells, given as MSB first for a preceding line level of 0: B=11101000 (subframe 0, frame 0), M=11100010 (subframe 0, frames 1-191), W=11100100 (subframe 1).
REQ-017 When the line level is 1 before slot 0, the preamble pattern SHALL be inverted; preambles SHALL NOT follow biphase-mark rules.
REQ-018 Slots 4-11 SHALL be 0 (aux and LSB extension).
REQ-019 Slots 12-27 SHALL carry the sample, LSB in slot 12 and MSB in slot 27.
REQ-020 Slot 28 (V) SHALL be 0.
REQ-021 Slot 29 (U) SHALL be 0.
REQ-022 Slot 30 (C) SHALL be channel-status bit[frame], with the same value in both subframes.
REQ-023 Slot 31 (P) SHALL make the ones count over slots 4-31 even.
REQ-024 Slots 4-31 SHALL be biphase-mark coded: spdif toggles at half-cell 0 of every slot, and toggles again at half-cell 1 only if the bit is 1.
REQ-025 Channel status SHALL be:
- bit 0 = 0 (consumer);
- bit 2 = CS_COPY;
- bits 8-15 = CS_CATEGORY;
- bits 24-27 = 0,1,0,0 when sample_rate=0, and 0,1,0,1 when sample_rate=1;
- all other bits 0.
REQ-026 sample_rate SHALL be sampled at frame 0 and held for the whole block.
REQ-027 The output transition SHALL occur on the same clk edge as the qualifying ce, registered with no glitches.
REQ-028 If ce is asserted on every clk, operation SHALL be correct at one half-cell per clk.

Reset
REQ-029 Reset SHALL asynchronously clear spdif=0, sample_ack=0, all counters=0 and the latched samples=0.
REQ-030 After reset release, the first ce SHALL begin preamble B of frame 0 with a preceding line level of 0.
REQ-031 Reset asserted mid-subframe SHALL abort the subframe immediately, with no completion of the partial frame.

Structure
REQ-032 A shared package spdif_pkg SHALL hold the preamble constants B/M/W, FRAMES_PER_BLOCK=192, SLOTS_PER_SUBFRAME=32, channel-status bit indices, and sample-rate codes.
REQ-033 One sub-module spdif_bmc SHALL be instantiated, holding the line-level register plus the biphase and preamble-inversion logic; the slot, frame and channel-status sequencing SHALL remain in spdif_tx.

Verification
REQ-034 Drive reset, then ce every 4 clk with left=16'h8001 and right=16'h7FFE -> first 8 half-cells = 11101000; left slots 12-27 decode 8001; parity even; sample_ack pulses once per 128 ce.
REQ-035 Run 2 blocks with a decoder model -> preamble B appears exactly at frames 0 and 192, M on the other left subframes, W on every right subframe.
REQ-036 Hold sample_rate=1, collect the C bits over 192 frames -> bits 2 and 25 and 27 = 1 and all others 0; with sample_rate=0, bit 27 = 0.
REQ-037 Input 16'h0000 on both channels -> line toggles only at cell boundaries in slots 4-31 and the P bit is 0; input 16'hFFFF -> P=0 and 16 mid-cell toggles.
REQ-038 Assert reset at frame 37, slot 15 -> spdif=0 in the same cycle; after release the frame starts with B and the decoded samples are the new inputs.
REQ-039 Hold ce low for 50 clk mid-slot -> spdif and counters freeze; the stream resumes with no missing or extra half-cells.
